// File: rtl/iob_cache_axi_line_fill_pkg.sv
// Shared state encodings and AXI constants for the
// cache line-fill AXI read master.
package iob_cache_axi_line_fill_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_RD   = 2'd2
  } state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] BURST_WRAP = 2'b10;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

endpackage

// File: rtl/iob_cache_axi_beat_cnt.sv
// Beat index within a line (modulo line size) plus a
// count of beats received, flagging the final one.
module iob_cache_axi_beat_cnt #(
  parameter int LINE_BEATS_W = 2,
  parameter int AW           = 2
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          load_i,
  input  logic [AW-1:0] start_i,
  input  logic          inc_i,
  output logic [AW-1:0] idx_o,
  output logic          final_o
);

  localparam int CW = LINE_BEATS_W + 1;
  localparam logic [AW-1:0] MASK =
    AW'((1 << LINE_BEATS_W) - 1);
  localparam logic [CW-1:0] LAST =
    CW'((1 << LINE_BEATS_W) - 1);

  logic [AW-1:0] idx_q;
  logic [CW-1:0] n_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      idx_q <= '0;
      n_q   <= '0;
    end else if (load_i) begin
      idx_q <= start_i & MASK;
      n_q   <= '0;
    end else if (inc_i) begin
      idx_q <= (idx_q + AW'(1)) & MASK;
      n_q   <= n_q + CW'(1);
    end
  end

  assign idx_o   = idx_q;
  assign final_o = (n_q == LAST);

endmodule

// File: rtl/iob_cache_axi_line_fill.sv
// AXI4 read master filling one cache line per request,
// critical-word-first (WRAP) or from line start (INCR).
module iob_cache_axi_line_fill
  import iob_cache_axi_line_fill_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int LINE_BEATS_W = 2,
  parameter int AXI_ID_W     = 1,
  parameter int AXI_ID       = 0,
  parameter int WRAP_EN      = 1,
  localparam int AW = (LINE_BEATS_W < 1) ? 1 : LINE_BEATS_W
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [ADDR_W-1:0]   req_addr_i,
  output logic                fill_valid_o,
  output logic [AW-1:0]       fill_addr_o,
  output logic [DATA_W-1:0]   fill_data_o,
  output logic                fill_last_o,
  output logic                err_o,
  output logic [AXI_ID_W-1:0] m_axi_arid_o,
  output logic [ADDR_W-1:0]   m_axi_araddr_o,
  output logic [7:0]          m_axi_arlen_o,
  output logic [2:0]          m_axi_arsize_o,
  output logic [1:0]          m_axi_arburst_o,
  output logic                m_axi_arvalid_o,
  input  logic                m_axi_arready_i,
  input  logic [AXI_ID_W-1:0] m_axi_rid_i,
  input  logic [DATA_W-1:0]   m_axi_rdata_i,
  input  logic [1:0]          m_axi_rresp_i,
  input  logic                m_axi_rlast_i,
  input  logic                m_axi_rvalid_i,
  output logic                m_axi_rready_o
);

  localparam int SZ = $clog2(DATA_W / 8);
  localparam bit WRAP =
    (WRAP_EN != 0) && (LINE_BEATS_W >= 1);
  localparam int LOW = WRAP ? SZ : SZ + LINE_BEATS_W;
  localparam logic [ADDR_W-1:0] AMASK =
    ~((ADDR_W'(1) << LOW) - ADDR_W'(1));

  state_t state_q, state_d;

  logic                accept;
  logic                beat;
  logic                fin;
  logic                beat_last;
  logic                beat_err;
  logic [AW-1:0]       crit;
  logic [AW-1:0]       idx;
  logic [ADDR_W-1:0]   araddr_q;
  logic                err_acc_q;
  logic                fv_q;
  logic [AW-1:0]       fa_q;
  logic [DATA_W-1:0]   fd_q;
  logic                fl_q;
  logic                fe_q;

  assign accept = req_valid_i & req_ready_o;
  assign beat   = (state_q == ST_RD) & m_axi_rvalid_i;
  assign crit   = WRAP ? req_addr_i[SZ +: AW] : '0;

  // rlast xor expected-final catches both early and missing rlast
  assign beat_last = m_axi_rlast_i | fin;
  assign beat_err  = (m_axi_rresp_i != RESP_OKAY)
                   | (m_axi_rid_i != AXI_ID_W'(AXI_ID))
                   | (m_axi_rlast_i ^ fin);

  iob_cache_axi_beat_cnt #(
    .LINE_BEATS_W (LINE_BEATS_W),
    .AW           (AW)
  ) u_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load_i  (accept),
    .start_i (crit),
    .inc_i   (beat),
    .idx_o   (idx),
    .final_o (fin)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_AR;
      ST_AR:   if (m_axi_arready_i) state_d = ST_RD;
      ST_RD:   if (beat && beat_last) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      araddr_q  <= '0;
      err_acc_q <= 1'b0;
      fv_q      <= 1'b0;
      fa_q      <= '0;
      fd_q      <= '0;
      fl_q      <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      if (accept) begin
        araddr_q  <= req_addr_i & AMASK;
        err_acc_q <= 1'b0;
      end else if (beat) begin
        err_acc_q <= err_acc_q | beat_err;
      end
      fv_q <= beat;
      fl_q <= beat & beat_last;
      fe_q <= beat & beat_last & (err_acc_q | beat_err);
      if (beat) begin
        fa_q <= idx;
        fd_q <= m_axi_rdata_i;
      end
    end
  end

  assign req_ready_o     = (state_q == ST_IDLE);
  assign m_axi_arvalid_o = (state_q == ST_AR);
  assign m_axi_rready_o  = (state_q == ST_RD);

  // AR fields are zero outside the address phase
  assign m_axi_arid_o    = m_axi_arvalid_o ?
    AXI_ID_W'(AXI_ID) : '0;
  assign m_axi_araddr_o  = m_axi_arvalid_o ? araddr_q : '0;
  assign m_axi_arlen_o   = m_axi_arvalid_o ?
    8'((1 << LINE_BEATS_W) - 1) : 8'd0;
  assign m_axi_arsize_o  = m_axi_arvalid_o ? 3'(SZ) : 3'd0;
  assign m_axi_arburst_o = !m_axi_arvalid_o ? 2'b00 :
    (WRAP ? BURST_WRAP : BURST_INCR);

  assign fill_valid_o = fv_q;
  assign fill_addr_o  = fa_q;
  assign fill_data_o  = fd_q;
  assign fill_last_o  = fl_q;
  assign err_o        = fe_q;

endmodule

// File: tb/tb_iob_cache_axi_line_fill.sv
// Randomized bench: WRAP and INCR instances share stimulus
// and are checked against a line-fill model every cycle.
module tb_iob_cache_axi_line_fill;

  typedef struct {
    int          aw;
    int          ac;
    logic [31:0] d;
    bit          last;
    bit          err;
  } exp_t;

  typedef struct {
    int aw;
    int ac;
    bit last;
    bit err;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        arready = 1'b0;
  logic [0:0]  rid = '0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0;
  logic        rlast = 1'b0;
  logic        rvalid = 1'b0;

  logic        w_req_ready, c_req_ready;
  logic        w_fv, c_fv;
  logic [1:0]  w_fa, c_fa;
  logic [31:0] w_fd, c_fd;
  logic        w_fl, c_fl;
  logic        w_err, c_err;
  logic [0:0]  w_arid, c_arid;
  logic [31:0] w_araddr, c_araddr;
  logic [7:0]  w_arlen, c_arlen;
  logic [2:0]  w_arsize, c_arsize;
  logic [1:0]  w_arburst, c_arburst;
  logic        w_arvalid, c_arvalid;
  logic        w_rready, c_rready;

  int checks = 0;
  int errors = 0;

  exp_t q[$];
  obs_t obs[$];

  logic [31:0] bd[8];
  bit          bl[8];
  logic [1:0]  br[8];
  logic [0:0]  bi[8];
  int          nb;

  always #5 clk = ~clk;

  iob_cache_axi_line_fill #(
    .ADDR_W(32), .DATA_W(32), .LINE_BEATS_W(2),
    .AXI_ID_W(1), .AXI_ID(0), .WRAP_EN(1)
  ) u_wrap (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(w_req_ready),
    .req_addr_i(req_addr),
    .fill_valid_o(w_fv), .fill_addr_o(w_fa),
    .fill_data_o(w_fd), .fill_last_o(w_fl), .err_o(w_err),
    .m_axi_arid_o(w_arid), .m_axi_araddr_o(w_araddr),
    .m_axi_arlen_o(w_arlen), .m_axi_arsize_o(w_arsize),
    .m_axi_arburst_o(w_arburst), .m_axi_arvalid_o(w_arvalid),
    .m_axi_arready_i(arready),
    .m_axi_rid_i(rid), .m_axi_rdata_i(rdata),
    .m_axi_rresp_i(rresp), .m_axi_rlast_i(rlast),
    .m_axi_rvalid_i(rvalid), .m_axi_rready_o(w_rready)
  );

  iob_cache_axi_line_fill #(
    .ADDR_W(32), .DATA_W(32), .LINE_BEATS_W(2),
    .AXI_ID_W(1), .AXI_ID(0), .WRAP_EN(0)
  ) u_incr (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(c_req_ready),
    .req_addr_i(req_addr),
    .fill_valid_o(c_fv), .fill_addr_o(c_fa),
    .fill_data_o(c_fd), .fill_last_o(c_fl), .err_o(c_err),
    .m_axi_arid_o(c_arid), .m_axi_araddr_o(c_araddr),
    .m_axi_arlen_o(c_arlen), .m_axi_arsize_o(c_arsize),
    .m_axi_arburst_o(c_arburst), .m_axi_arvalid_o(c_arvalid),
    .m_axi_arready_i(arready),
    .m_axi_rid_i(rid), .m_axi_rdata_i(rdata),
    .m_axi_rresp_i(rresp), .m_axi_rlast_i(rlast),
    .m_axi_rvalid_i(rvalid), .m_axi_rready_o(c_rready)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare process: every fill beat must match the model queue
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && (w_fv || c_fv)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_fill actual=%0d%0d required=00",
                 w_fv, c_fv);
      end else begin
        e = q.pop_front();
        chk("fill_valid_pair", {w_fv, c_fv}, 2'b11);
        chk("fill_addr_wrap", w_fa, e.aw);
        chk("fill_addr_incr", c_fa, e.ac);
        chk("fill_data_wrap", w_fd, e.d);
        chk("fill_data_incr", c_fd, e.d);
        chk("fill_last_wrap", w_fl, e.last);
        chk("fill_last_incr", c_fl, e.last);
        if (e.last) begin
          chk("err_wrap", w_err, e.err);
          chk("err_incr", c_err, e.err);
        end
        obs.push_back('{int'(w_fa), int'(c_fa), w_fl, w_err});
      end
    end
  end

  task automatic set_beats(input int n);
    for (int i = 0; i < 8; i++) begin
      bd[i] = $urandom;
      bl[i] = (i == 3);
      br[i] = 2'b00;
      bi[i] = 1'b0;
    end
    nb = n;
  endtask

  task automatic run_line(input logic [31:0] addr,
                          input int ard);
    int  crit;
    bit  acc;
    bit  done;
    exp_t e;
    obs.delete();
    chk("req_ready_idle", w_req_ready & c_req_ready, 1);
    req_valid = 1'b1;
    req_addr  = addr;
    step();
    req_valid = 1'b0;
    req_addr  = $urandom;
    chk("arvalid", {w_arvalid, c_arvalid}, 2'b11);
    chk("araddr_wrap", w_araddr, addr & ~32'h3);
    chk("araddr_incr", c_araddr, addr & ~32'hf);
    chk("arlen", {w_arlen, c_arlen}, {8'd3, 8'd3});
    chk("arsize", {w_arsize, c_arsize}, {3'd2, 3'd2});
    chk("arburst", {w_arburst, c_arburst}, {2'd2, 2'd1});
    chk("arid", {w_arid, c_arid}, 2'b00);
    chk("req_ready_busy", w_req_ready | c_req_ready, 0);
    repeat (ard) begin
      step();
      chk("arvalid_hold", {w_arvalid, c_arvalid}, 2'b11);
      chk("araddr_hold", w_araddr, addr & ~32'h3);
      chk("req_ready_hold", w_req_ready | c_req_ready, 0);
    end
    arready = 1'b1;
    step();
    arready = 1'b0;
    chk("arvalid_drop", w_arvalid | c_arvalid, 0);
    crit = (addr >> 2) & 3;
    acc  = 1'b0;
    done = 1'b0;
    for (int i = 0; i < nb; i++) begin
      repeat ($urandom_range(0, 2)) step();
      rvalid = 1'b1;
      rid    = bi[i];
      rdata  = bd[i];
      rresp  = br[i];
      rlast  = bl[i];
      if (!done) begin
        chk("rready_rd", {w_rready, c_rready}, 2'b11);
        acc = acc | (br[i] != 0) | (bi[i] != 0)
                  | (bl[i] && i < 3) | (i == 3 && !bl[i]);
        e.aw   = (crit + i) % 4;
        e.ac   = i % 4;
        e.d    = bd[i];
        e.last = bl[i] || (i == 3);
        e.err  = e.last && acc;
        q.push_back(e);
        done = e.last;
      end else begin
        chk("rready_stray", w_rready | c_rready, 0);
      end
      step();
      rvalid = 1'b0;
      rlast  = 1'b0;
    end
    repeat (3) step();
    chk("fills_drained", q.size(), 0);
    chk("back_idle", w_req_ready & c_req_ready, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int mode;
    int k;
    #2;
    chk("rst_req_ready", {w_req_ready, c_req_ready}, 2'b11);
    chk("rst_arvalid", w_arvalid | c_arvalid, 0);
    chk("rst_rready", w_rready | c_rready, 0);
    chk("rst_fill", w_fv | c_fv | w_fl | c_fl | w_err, 0);
    chk("rst_araddr", w_araddr | c_araddr, 0);
    step();
    rst_n = 1'b1;
    step();

    // critical word first at 0x1008
    set_beats(4);
    bd[0] = 32'hA; bd[1] = 32'hB; bd[2] = 32'hC; bd[3] = 32'hD;
    run_line(32'h1008, 0);
    chk("lit_n", obs.size(), 4);
    if (obs.size() == 4) begin
      chk("lit_aw0", obs[0].aw, 2);
      chk("lit_aw1", obs[1].aw, 3);
      chk("lit_aw2", obs[2].aw, 0);
      chk("lit_aw3", obs[3].aw, 1);
      chk("lit_ac0", obs[0].ac, 0);
      chk("lit_ac3", obs[3].ac, 3);
      chk("lit_last", {obs[2].last, obs[3].last}, 2'b01);
      chk("lit_err", obs[3].err, 0);
    end

    // arready held off
    set_beats(4);
    run_line(32'h0000_4abc, 5);

    // early rlast on 2nd beat
    set_beats(4);
    bl[1] = 1'b1;
    run_line(32'h1008, 1);
    chk("early_n", obs.size(), 2);
    if (obs.size() == 2)
      chk("early_last_err", {obs[1].last, obs[1].err}, 2'b11);

    // SLVERR on first beat
    set_beats(4);
    br[0] = 2'd2;
    run_line(32'h1004, 0);
    chk("resp_n", obs.size(), 4);
    if (obs.size() == 4)
      chk("resp_last_err", {obs[3].last, obs[3].err}, 2'b11);

    // rlast missing, one stray beat afterwards
    set_beats(5);
    bl[3] = 1'b0;
    run_line(32'h500c, 2);
    chk("norlast_n", obs.size(), 4);
    if (obs.size() == 4)
      chk("norlast_last_err", {obs[3].last, obs[3].err}, 2'b11);

    // wrong RID
    set_beats(4);
    bi[2] = 1'b1;
    run_line(32'h600c, 0);

    // reset in the middle of a burst
    req_valid = 1'b1;
    req_addr  = 32'h3004;
    step();
    req_valid = 1'b0;
    arready   = 1'b1;
    step();
    arready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      rvalid = 1'b1;
      rdata  = $urandom;
      e.aw = (1 + i) % 4; e.ac = i; e.d = rdata;
      e.last = 1'b0; e.err = 1'b0;
      q.push_back(e);
      step();
      rvalid = 1'b0;
    end
    #1;
    rst_n = 1'b0;
    #1;
    q.delete();
    chk("mid_rst_arvalid", w_arvalid | c_arvalid, 0);
    chk("mid_rst_rready", w_rready | c_rready, 0);
    chk("mid_rst_fill", w_fv | c_fv, 0);
    chk("mid_rst_ready", {w_req_ready, c_req_ready}, 2'b11);
    rvalid = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    repeat (4) begin
      step();
      chk("post_rst_quiet", w_fv | c_fv | w_rready, 0);
    end
    rvalid = 1'b0;
    step();
    set_beats(4);
    run_line(32'h2000, 1);
    chk("post_rst_n", obs.size(), 4);
    if (obs.size() == 4)
      chk("post_rst_aw0", obs[0].aw, 0);

    // randomized traffic
    for (int t = 0; t < 24; t++) begin
      mode = $urandom_range(0, 6);
      set_beats(4);
      k = $urandom_range(0, 2);
      case (mode)
        3: bl[k] = 1'b1;
        4: br[$urandom_range(0, 3)] = 2'($urandom_range(1, 3));
        5: begin nb = 5; bl[3] = 1'b0; end
        6: bi[$urandom_range(0, 3)] = 1'b1;
        default: ;
      endcase
      run_line($urandom, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
